// File: rtl/sel_pipe_stage.sv
// sel_pipe_stage: N-way, W-bit registered selector with valid/ready
// handshake and a one-entry skid buffer.
//
// An operand is picked from in_data by in_sel and registered into the main
// register (out_*). If downstream stalls while a beat is being accepted, that
// beat parks in the skid register so in_ready can be a pure register output.
// Select codes at or above N_IN yield zero data, raise out_err and bump a
// saturating error counter.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   flush      synchronous squash of all held beats (data registers retained)
//   in_data    N_IN packed inputs, input k at [k*WIDTH +: WIDTH]
//   in_sel     select code
//   in_valid   upstream offers in_data/in_sel
//   in_ready   stage can accept this cycle (registered)
//   out_data   selected, registered data
//   out_err    out_data came from an out-of-range select
//   out_valid  out_data/out_err valid
//   out_ready  downstream accepts this cycle
//   err_cnt    saturating count of accepted out-of-range selects

module sel_pipe_stage #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned N_IN  = 8,
    parameter int unsigned SEL_W = (N_IN > 1) ? $clog2(N_IN) : 1,
    parameter int unsigned CNT_W = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    flush,
    input  logic [N_IN*WIDTH-1:0]   in_data,
    input  logic [SEL_W-1:0]        in_sel,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_err,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [CNT_W-1:0]        err_cnt
);

    localparam int unsigned SEL_CMP_W = 32;

    // Select: one-hot decode of in_sel, then an AND-OR chain over the inputs
    logic [N_IN-1:0]            hit;
    logic [N_IN:0][WIDTH-1:0]   sel_chain;
    logic [WIDTH-1:0]           sel_data;
    logic                       sel_err;

    assign sel_chain[0] = '0;

    for (genvar g = 0; g < N_IN; g++) begin : g_sel
        assign hit[g]         = (SEL_CMP_W'(in_sel) == SEL_CMP_W'(g));
        assign sel_chain[g+1] = sel_chain[g] |
                                (hit[g] ? in_data[g*WIDTH +: WIDTH] : '0);
    end

    // No decode hit means the code is out of range; data is then all zeros
    assign sel_data = sel_chain[N_IN];
    assign sel_err  = ~|hit;

    // Skid register
    logic               s_valid;
    logic [WIDTH-1:0]   s_data;
    logic               s_err;

    // Next-state values
    logic               out_valid_nxt;
    logic [WIDTH-1:0]   out_data_nxt;
    logic               out_err_nxt;
    logic               s_valid_nxt;
    logic [WIDTH-1:0]   s_data_nxt;
    logic               s_err_nxt;
    logic               in_ready_nxt;
    logic [CNT_W-1:0]   err_cnt_nxt;

    logic               acc;
    logic               m_free;

    assign acc    = in_valid & in_ready;
    assign m_free = ~out_valid | out_ready;

    // Next-state logic: flush first, then refill M (from S before new input),
    // else park an accepted beat in S while M is stalled
    always_comb begin
        out_valid_nxt = out_valid;
        out_data_nxt  = out_data;
        out_err_nxt   = out_err;
        s_valid_nxt   = s_valid;
        s_data_nxt    = s_data;
        s_err_nxt     = s_err;
        err_cnt_nxt   = err_cnt;

        if (flush) begin
            out_valid_nxt = 1'b0;
            s_valid_nxt   = 1'b0;
        end else if (m_free) begin
            if (s_valid) begin
                // in_ready was low, so nothing can be accepted here
                out_valid_nxt = 1'b1;
                out_data_nxt  = s_data;
                out_err_nxt   = s_err;
                s_valid_nxt   = 1'b0;
            end else if (acc) begin
                out_valid_nxt = 1'b1;
                out_data_nxt  = sel_data;
                out_err_nxt   = sel_err;
            end else begin
                out_valid_nxt = 1'b0;
            end
        end else if (acc) begin
            s_valid_nxt = 1'b1;
            s_data_nxt  = sel_data;
            s_err_nxt   = sel_err;
        end

        // Dropped-by-flush beats are not counted
        if (!flush && acc && sel_err && (err_cnt != {CNT_W{1'b1}})) begin
            err_cnt_nxt = err_cnt + CNT_W'(1);
        end

        in_ready_nxt = ~s_valid_nxt;
    end

    // State registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_err   <= 1'b0;
            s_valid   <= 1'b0;
            s_data    <= '0;
            s_err     <= 1'b0;
            in_ready  <= 1'b1;
            err_cnt   <= '0;
        end else begin
            out_valid <= out_valid_nxt;
            out_data  <= out_data_nxt;
            out_err   <= out_err_nxt;
            s_valid   <= s_valid_nxt;
            s_data    <= s_data_nxt;
            s_err     <= s_err_nxt;
            in_ready  <= in_ready_nxt;
            err_cnt   <= err_cnt_nxt;
        end
    end

    // Structural invariants
    a_ready_mirrors_skid: assert property (@(posedge clk) disable iff (!rst_n)
        in_ready == ~s_valid);

    a_skid_implies_main: assert property (@(posedge clk) disable iff (!rst_n)
        !(s_valid && !out_valid));

    a_stall_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (out_valid && !out_ready) |=> ($stable(out_data) && $stable(out_err)));

endmodule

// File: doc/sel_pipe_stage.md
# sel_pipe_stage

Parametrised N-way, W-bit registered selector with valid/ready handshake and a one-entry skid buffer. It replaces the fixed-width combinational selectors (2/4/8-way, 5/32-bit) wherever a selected operand must cross a pipeline boundary. Typical uses are operand and writeback selection feeding the next CPU stage. It supports backpressure and stall without data loss, a synchronous flush for branch and exception squash, and detection and counting of out-of-range select codes.

## Interface
Parameters:
- WIDTH, 32, data width of each input and of the output
- N_IN, 8, number of selectable inputs (2..16; need not be a power of two)
- SEL_W, $clog2(N_IN), select field width (minimum 1)
- CNT_W, 16, width of the error counter

Ports:
- clk  input  1  rising-edge clock, the only clock
- rst_n  input  1  synchronous, active-low reset
- flush  input  1  synchronous squash of all held data
- in_data  input  N_IN*WIDTH  packed inputs; input k is bits [k*WIDTH +: WIDTH]
- in_sel  input  SEL_W  select code
- in_valid  input  1  upstream offers in_data/in_sel
- in_ready  output  1  stage can accept this cycle
- out_data  output  WIDTH  selected, registered data
- out_err  output  1  out_data came from an out-of-range select
- out_valid  output  1  out_data/out_err valid
- out_ready  input  1  downstream accepts this cycle
- err_cnt  output  CNT_W  saturating count of accepted out-of-range selects

## Operation
- Select (combinational): if in_sel < N_IN, sel_data = input[in_sel] and sel_err = 0. Otherwise sel_data = 0 and sel_err = 1.
- Storage:
  - Main register M: out_valid, out_data, out_err.
  - Skid register S: s_valid, s_data, s_err.
- in_ready = !s_valid. It is driven from a register only; there is no combinational path from out_ready.
- Definitions: acc = in_valid & in_ready; drain = out_valid & out_ready; m_free = !out_valid | out_ready.
- Per-cycle update, in priority order:
  - !rst_n: out_valid=0, s_valid=0, out_data=0, out_err=0, s_data=0, s_err=0, err_cnt=0.
  - flush: out_valid=0 and s_valid=0. Any input offered in this cycle is dropped and not counted. Data registers keep their values. err_cnt is unchanged.
  - m_free & s_valid: M takes S; s_valid=0. acc is impossible in this case.
  - m_free & !s_valid & acc: M takes sel_data/sel_err; out_valid=1.
  - m_free & !s_valid & !acc: out_valid=0.
  - !m_free & acc: S takes sel_data/sel_err; s_valid=1. M holds.
  - !m_free & !acc: hold.
- err_cnt increments on each acc with sel_err=1, except in a flush cycle. It saturates at 2^CNT_W-1.
- out_data/out_err remain stable while out_valid=1 and out_ready=0.
- Ordering is strictly FIFO: S is never overtaken by new input.

## Timing
- Reset values: in_ready=1, out_valid=0, out_data=0, out_err=0, err_cnt=0.
- Latency: acc in cycle t gives out_valid=1 with that data in cycle t+1, provided M is free.
- Throughput: 1 transfer per cycle with out_ready held at 1.
- Backpressure: if out_ready drops while streaming, one extra beat is absorbed in S and in_ready falls the next cycle. When out_ready returns, S moves to M in 1 cycle and in_ready rises the cycle after.
- Maximum occupancy is 2. The stage is full when out_valid=1 and s_valid=1, with in_ready=0.
- Flush and out_ready=1 in the same cycle: the beat on out_data is considered transferred (downstream decides). The stage is still empty afterwards.
- Reset or flush mid-stream: the next cycle has out_valid=0 and in_ready=1, and no stale beat reappears.
- Out-of-range codes exist only when N_IN is not a power of two. When N_IN = 2^SEL_W, out_err is constant 0.

## Test plan
- Reset: drive rst_n=0 for 2 cycles with in_valid=1 -> in_ready=1, out_valid=0, out_data=0, err_cnt=0; no beat emerges after release.
- Stream, N_IN=8, WIDTH=32: input k = 0x1000_0000+k, in_sel = 0,1,...,7 on consecutive cycles, out_ready=1 -> out_data 0x1000_0000..0x1000_0007 one cycle later each, no bubbles.
- Backpressure: stream 4 beats, set out_ready=0 after the first output -> exactly one beat lands in S, in_ready=0 the next cycle. Release out_ready -> all 4 beats appear in order, none lost or duplicated.
- Out-of-range, N_IN=5, SEL_W=3: in_sel=6 accepted -> out_data=0, out_err=1, err_cnt=1. With CNT_W=2 and 5 such beats -> err_cnt saturates at 3.
- Flush: fill the stage (out_valid=1, in_ready=0), assert flush together with in_valid=1, in_sel=2 -> next cycle out_valid=0, in_ready=1, err_cnt unchanged, and the in_sel=2 beat never appears.
- Reset mid-operation: with a full stage, drive rst_n=0 for 1 cycle -> next cycle out_valid=0, out_data=0, err_cnt=0, in_ready=1.
